legv8_pipe_ctrl: RTL and testbench

Pipelined control unit for the 5-stage LEGv8 core: decodes the 11-bit opcode in ID and carries the control bundle through registered ID/EX, EX/MEM and MEM/WB stages. It detects load-use hazards (stall plus bubble) and squashes on taken branches (flush). It flags illegal opcodes and keeps saturating stall/flush counters. It sits between the IF/ID register and the datapath stage registers, replacing the single-cycle decoder.

---
 rtl/legv8_pipe_ctrl_pkg.sv | 64 ++++++
 rtl/legv8_pipe_ctrl_if.sv | 57 +++++
 rtl/legv8_pipe_ctrl_decode.sv | 68 ++++++
 rtl/legv8_pipe_ctrl.sv | 104 ++++++++++
 tb/tb_legv8_pipe_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/legv8_pipe_ctrl_pkg.sv
// Shared opcodes, ALUop encodings and stage control bundles for the LEGv8 pipeline control.
package legv8_pkg;

    localparam int unsigned OP_W    = 11;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned ALUOP_W = 2;

    localparam logic [OP_W-1:0]  OP_LDUR = 11'd1986;
    localparam logic [OP_W-1:0]  OP_STUR = 11'd1984;
    localparam logic [OP_W-1:0]  OP_ADD  = 11'd1112;
    localparam logic [OP_W-1:0]  OP_SUB  = 11'd1624;
    localparam logic [OP_W-1:0]  OP_AND  = 11'd1104;
    localparam logic [OP_W-1:0]  OP_ORR  = 11'd1360;
    localparam logic [7:0]       OP_CBZ  = 8'd180;
    localparam logic [7:0]       OP_CBNZ = 8'd181;
    localparam logic [5:0]       OP_B    = 6'd5;
    localparam logic [9:0]       OP_ADDI = 10'd580;
    localparam logic [9:0]       OP_SUBI = 10'd836;

    localparam logic [REG_W-1:0] REG_ZR  = 5'd31;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD   = 2'b00,
        ALU_PASSB = 2'b01,
        ALU_FUNCT = 2'b10
    } aluop_e;

    typedef struct packed {
        logic             valid;
        aluop_e           ALUop;
        logic             ALUSrc;
        logic             Branch;
        logic             UBranch;
        logic             BrNZ;
        logic             MemRead;
        logic             MemWrite;
        logic             MemtoReg;
        logic             RegWrite;
        logic [REG_W-1:0] rd;
    } ctrl_t;

    typedef struct packed {
        logic             valid;
        logic             MemRead;
        logic             MemWrite;
        logic             MemtoReg;
        logic             RegWrite;
        logic [REG_W-1:0] rd;
    } mem_t;

    typedef struct packed {
        logic             valid;
        logic             MemtoReg;
        logic             RegWrite;
        logic [REG_W-1:0] rd;
    } wb_t;

    localparam ctrl_t CTRL_BUBBLE = '{valid: 1'b0, ALUop: ALU_ADD, ALUSrc: 1'b0, Branch: 1'b0,
                                      UBranch: 1'b0, BrNZ: 1'b0, MemRead: 1'b0, MemWrite: 1'b0,
                                      MemtoReg: 1'b0, RegWrite: 1'b0, rd: 5'd0};
    localparam mem_t  MEM_BUBBLE  = '0;
    localparam wb_t   WB_BUBBLE   = '0;

endpackage

// File: rtl/legv8_pipe_ctrl_if.sv
// ID-side inputs and pipelined control outputs of the LEGv8 control unit.
interface legv8_pipe_ctrl_if
    import legv8_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);
    logic [OP_W-1:0]    Inst;
    logic               id_valid;
    logic [REG_W-1:0]   id_rn;
    logic [REG_W-1:0]   id_rm;
    logic [REG_W-1:0]   id_rt;
    logic               branch_taken;

    logic               Reg2Loc;
    logic               illegal;
    logic               stall;
    logic               flush;

    logic               ex_valid;
    logic [ALUOP_W-1:0] ex_ALUop;
    logic               ex_ALUSrc;
    logic               ex_Branch;
    logic               ex_UBranch;
    logic               ex_BrNZ;
    logic [REG_W-1:0]   ex_rd;

    logic               mem_valid;
    logic               mem_MemRead;
    logic               mem_MemWrite;
    logic [REG_W-1:0]   mem_rd;

    logic               wb_valid;
    logic               wb_MemtoReg;
    logic               wb_RegWrite;
    logic [REG_W-1:0]   wb_rd;

    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    modport master (
        output Inst, id_valid, id_rn, id_rm, id_rt, branch_taken,
        input  Reg2Loc, illegal, stall, flush,
        input  ex_valid, ex_ALUop, ex_ALUSrc, ex_Branch, ex_UBranch, ex_BrNZ, ex_rd,
        input  mem_valid, mem_MemRead, mem_MemWrite, mem_rd,
        input  wb_valid, wb_MemtoReg, wb_RegWrite, wb_rd,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  Inst, id_valid, id_rn, id_rm, id_rt, branch_taken,
        output Reg2Loc, illegal, stall, flush,
        output ex_valid, ex_ALUop, ex_ALUSrc, ex_Branch, ex_UBranch, ex_BrNZ, ex_rd,
        output mem_valid, mem_MemRead, mem_MemWrite, mem_rd,
        output wb_valid, wb_MemtoReg, wb_RegWrite, wb_rd,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/legv8_pipe_ctrl_decode.sv
// Combinational LEGv8 opcode decoder: control bundle, source-register usage and illegal flag.
module legv8_decode
    import legv8_pkg::*;
#(
    parameter bit EXT_ISA = 1'b1
) (
    input  logic [OP_W-1:0] Inst,
    output ctrl_t           ctrl,
    output logic            illegal,
    output logic            Reg2Loc,
    output logic            uses_rn,
    output logic            uses_rm,
    output logic            uses_rt
);
    always_comb begin
        ctrl    = CTRL_BUBBLE;
        illegal = 1'b0;
        Reg2Loc = 1'b0;
        uses_rn = 1'b0;
        uses_rm = 1'b0;
        uses_rt = 1'b0;
        if (Inst == OP_LDUR) begin
            ctrl.valid    = 1'b1;
            ctrl.MemRead  = 1'b1;
            ctrl.MemtoReg = 1'b1;
            ctrl.ALUSrc   = 1'b1;
            ctrl.RegWrite = 1'b1;
            uses_rn       = 1'b1;
        end else if (Inst == OP_STUR) begin
            ctrl.valid    = 1'b1;
            ctrl.MemWrite = 1'b1;
            ctrl.ALUSrc   = 1'b1;
            Reg2Loc       = 1'b1;
            uses_rn       = 1'b1;
            uses_rt       = 1'b1;
        end else if (Inst[10:3] == OP_CBZ) begin
            ctrl.valid    = 1'b1;
            ctrl.Branch   = 1'b1;
            ctrl.ALUop    = ALU_PASSB;
            Reg2Loc       = 1'b1;
            uses_rt       = 1'b1;
        end else if (EXT_ISA && Inst[10:3] == OP_CBNZ) begin
            ctrl.valid    = 1'b1;
            ctrl.Branch   = 1'b1;
            ctrl.BrNZ     = 1'b1;
            ctrl.ALUop    = ALU_PASSB;
            Reg2Loc       = 1'b1;
            uses_rt       = 1'b1;
        end else if (Inst[10:5] == OP_B) begin
            ctrl.valid    = 1'b1;
            ctrl.UBranch  = 1'b1;
        end else if (EXT_ISA && (Inst[10:1] == OP_ADDI || Inst[10:1] == OP_SUBI)) begin
            ctrl.valid    = 1'b1;
            ctrl.ALUSrc   = 1'b1;
            ctrl.RegWrite = 1'b1;
            ctrl.ALUop    = ALU_FUNCT;
            uses_rn       = 1'b1;
        end else if (Inst == OP_ADD || Inst == OP_SUB || Inst == OP_AND || Inst == OP_ORR) begin
            ctrl.valid    = 1'b1;
            ctrl.RegWrite = 1'b1;
            ctrl.ALUop    = ALU_FUNCT;
            uses_rn       = 1'b1;
            uses_rm       = 1'b1;
        end else begin
            illegal = 1'b1;
        end
    end
endmodule

// File: rtl/legv8_pipe_ctrl.sv
// LEGv8 pipeline control: ID decode, ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall, branch flush and saturating event counters.
module legv8_pipe_ctrl
    import legv8_pkg::*;
#(
    parameter bit          EXT_ISA = 1'b1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic            clk,
    input  logic            rst,
    legv8_pipe_ctrl_if.slave bus
);
    ctrl_t            dec_ctrl;
    logic             dec_illegal;
    logic             dec_reg2loc;
    logic             uses_rn, uses_rm, uses_rt;
    logic             id_legal;
    logic             src_hit;
    logic             load_use;

    ctrl_t            ex_q, ex_d;
    mem_t             mem_q, mem_d;
    wb_t              wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    legv8_decode #(.EXT_ISA(EXT_ISA)) u_decode (
        .Inst    (bus.Inst),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal),
        .Reg2Loc (dec_reg2loc),
        .uses_rn (uses_rn),
        .uses_rm (uses_rm),
        .uses_rt (uses_rt)
    );

    // Load-use detection against the load sitting in EX; a taken branch kills it.
    always_comb begin
        id_legal = bus.id_valid & ~dec_illegal;
        src_hit  = (uses_rn & (bus.id_rn == ex_q.rd))
                 | (uses_rm & (bus.id_rm == ex_q.rd))
                 | (uses_rt & (bus.id_rt == ex_q.rd));
        load_use = ex_q.valid & ex_q.MemRead & (ex_q.rd != REG_ZR)
                 & id_legal & src_hit & ~bus.branch_taken;
    end

    always_comb begin
        ex_d = CTRL_BUBBLE;
        if (id_legal && !bus.branch_taken && !load_use) begin
            ex_d    = dec_ctrl;
            ex_d.rd = bus.id_rt;
        end
        mem_d = '{valid: ex_q.valid, MemRead: ex_q.MemRead, MemWrite: ex_q.MemWrite,
                  MemtoReg: ex_q.MemtoReg, RegWrite: ex_q.RegWrite, rd: ex_q.rd};
        wb_d  = '{valid: mem_q.valid, MemtoReg: mem_q.MemtoReg,
                  RegWrite: mem_q.RegWrite, rd: mem_q.rd};
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (load_use && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (bus.branch_taken && flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q        <= CTRL_BUBBLE;
            mem_q       <= MEM_BUBBLE;
            wb_q        <= WB_BUBBLE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.Reg2Loc      = dec_reg2loc;
    assign bus.illegal      = bus.id_valid & dec_illegal;
    assign bus.stall        = load_use;
    assign bus.flush        = bus.branch_taken;

    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_ALUop     = ex_q.ALUop;
    assign bus.ex_ALUSrc    = ex_q.ALUSrc;
    assign bus.ex_Branch    = ex_q.Branch;
    assign bus.ex_UBranch   = ex_q.UBranch;
    assign bus.ex_BrNZ      = ex_q.BrNZ;
    assign bus.ex_rd        = ex_q.rd;

    assign bus.mem_valid    = mem_q.valid;
    assign bus.mem_MemRead  = mem_q.MemRead;
    assign bus.mem_MemWrite = mem_q.MemWrite;
    assign bus.mem_rd       = mem_q.rd;

    assign bus.wb_valid     = wb_q.valid;
    assign bus.wb_MemtoReg  = wb_q.MemtoReg;
    assign bus.wb_RegWrite  = wb_q.RegWrite;
    assign bus.wb_rd        = wb_q.rd;

    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_legv8_pipe_ctrl.sv
// Bench for legv8_pipe_ctrl: two configurations driven in lockstep and compared to an
// instruction-level pipeline model every cycle.
module tb_legv8_pipe_ctrl;

    localparam int K_NONE = 0, K_LDUR = 1, K_STUR = 2, K_CBZ = 3, K_CBNZ = 4,
                   K_B = 5, K_ADDI = 6, K_R = 7, K_ILL = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [10:0] in_op = '0;
    logic        in_v  = 1'b0;
    logic [4:0]  in_rn = '0, in_rm = '0, in_rt = '0;
    logic        in_bt = 1'b0;

    legv8_pipe_ctrl_if #(.CNT_W(16)) bus_a ();
    legv8_pipe_ctrl_if #(.CNT_W(4))  bus_b ();

    assign bus_a.Inst = in_op;  assign bus_a.id_valid = in_v;  assign bus_a.branch_taken = in_bt;
    assign bus_a.id_rn = in_rn; assign bus_a.id_rm = in_rm;    assign bus_a.id_rt = in_rt;
    assign bus_b.Inst = in_op;  assign bus_b.id_valid = in_v;  assign bus_b.branch_taken = in_bt;
    assign bus_b.id_rn = in_rn; assign bus_b.id_rm = in_rm;    assign bus_b.id_rt = in_rt;

    legv8_pipe_ctrl #(.EXT_ISA(1'b1), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    legv8_pipe_ctrl #(.EXT_ISA(1'b0), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct packed {
        logic stall, flush, illegal, reg2loc, ex_valid;
        logic [1:0] ex_aluop;
        logic ex_alusrc, ex_branch, ex_ubranch, ex_brnz;
        logic [4:0] ex_rd;
        logic mem_valid, mem_memread, mem_memwrite;
        logic [4:0] mem_rd;
        logic wb_valid, wb_memtoreg, wb_regwrite;
        logic [4:0] wb_rd;
        logic [15:0] stall_cnt, flush_cnt;
    } obs_t;

    obs_t obs_a, obs_b;
    assign obs_a = '{bus_a.stall, bus_a.flush, bus_a.illegal, bus_a.Reg2Loc, bus_a.ex_valid,
                     bus_a.ex_ALUop, bus_a.ex_ALUSrc, bus_a.ex_Branch, bus_a.ex_UBranch, bus_a.ex_BrNZ,
                     bus_a.ex_rd, bus_a.mem_valid, bus_a.mem_MemRead, bus_a.mem_MemWrite, bus_a.mem_rd,
                     bus_a.wb_valid, bus_a.wb_MemtoReg, bus_a.wb_RegWrite, bus_a.wb_rd,
                     bus_a.stall_cnt, bus_a.flush_cnt};
    assign obs_b = '{bus_b.stall, bus_b.flush, bus_b.illegal, bus_b.Reg2Loc, bus_b.ex_valid,
                     bus_b.ex_ALUop, bus_b.ex_ALUSrc, bus_b.ex_Branch, bus_b.ex_UBranch, bus_b.ex_BrNZ,
                     bus_b.ex_rd, bus_b.mem_valid, bus_b.mem_MemRead, bus_b.mem_MemWrite, bus_b.mem_rd,
                     bus_b.wb_valid, bus_b.wb_MemtoReg, bus_b.wb_RegWrite, bus_b.wb_rd,
                     16'(bus_b.stall_cnt), 16'(bus_b.flush_cnt)};

    // Model: each stage holds an instruction kind and its destination; controls derive from kind.
    int ext_m [2] = '{1, 0};
    int cmax  [2] = '{65535, 15};
    int ex_k [2], ex_r [2], mem_k [2], mem_r [2], wb_k [2], wb_r [2], scnt [2], fcnt [2];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int kind_of(input logic [10:0] op, input int ext);
        logic [7:0] h8;
        logic [5:0] h6;
        logic [9:0] h10;
        h8 = op[10:3]; h6 = op[10:5]; h10 = op[10:1];
        if (op == 11'd1986) return K_LDUR;
        if (op == 11'd1984) return K_STUR;
        if (h8 == 8'd180) return K_CBZ;
        if (ext != 0 && h8 == 8'd181) return K_CBNZ;
        if (h6 == 6'd5) return K_B;
        if (ext != 0 && (h10 == 10'd580 || h10 == 10'd836)) return K_ADDI;
        if (op == 11'd1112 || op == 11'd1624 || op == 11'd1104 || op == 11'd1360) return K_R;
        return K_ILL;
    endfunction

    function automatic int alu_of(input int k);
        if (k == K_CBZ || k == K_CBNZ) return 1;
        if (k == K_ADDI || k == K_R) return 2;
        return 0;
    endfunction

    function automatic bit exp_hz(input int k);
        int  ik;
        bit  hit;
        ik  = kind_of(in_op, ext_m[k]);
        hit = ((ik == K_LDUR || ik == K_STUR || ik == K_ADDI || ik == K_R) && int'(in_rn) == ex_r[k])
           || ((ik == K_R) && int'(in_rm) == ex_r[k])
           || ((ik == K_STUR || ik == K_CBZ || ik == K_CBNZ) && int'(in_rt) == ex_r[k]);
        return ex_k[k] == K_LDUR && ex_r[k] != 31 && in_v && ik != K_ILL && hit && !in_bt;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ex_k[k] = 0; ex_r[k] = 0; mem_k[k] = 0; mem_r[k] = 0;
            wb_k[k] = 0; wb_r[k] = 0; scnt[k] = 0; fcnt[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int ik;
            bit hz;
            ik = kind_of(in_op, ext_m[k]);
            hz = exp_hz(k);
            if (hz && scnt[k] < cmax[k]) scnt[k]++;
            if (in_bt && fcnt[k] < cmax[k]) fcnt[k]++;
            wb_k[k] = mem_k[k]; wb_r[k] = mem_r[k];
            mem_k[k] = ex_k[k]; mem_r[k] = ex_r[k];
            if (in_v && ik != K_ILL && !hz && !in_bt) begin
                ex_k[k] = ik; ex_r[k] = int'(in_rt);
            end else begin
                ex_k[k] = 0; ex_r[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            obs_t  o;
            int    ik;
            string p;
            o  = (k == 0) ? obs_a : obs_b;
            ik = kind_of(in_op, ext_m[k]);
            p  = $sformatf("d%0d.", k);
            check({p, "stall"},     32'(o.stall),     32'(exp_hz(k)));
            check({p, "flush"},     32'(o.flush),     32'(in_bt));
            check({p, "illegal"},   32'(o.illegal),   32'(in_v && ik == K_ILL));
            check({p, "Reg2Loc"},   32'(o.reg2loc),   32'(ik == K_STUR || ik == K_CBZ || ik == K_CBNZ));
            check({p, "ex_valid"},  32'(o.ex_valid),  32'(ex_k[k] != 0));
            check({p, "ex_ALUop"},  32'(o.ex_aluop),  32'(alu_of(ex_k[k])));
            check({p, "ex_ALUSrc"}, 32'(o.ex_alusrc), 32'(ex_k[k] == K_LDUR || ex_k[k] == K_STUR || ex_k[k] == K_ADDI));
            check({p, "ex_Branch"}, 32'(o.ex_branch), 32'(ex_k[k] == K_CBZ || ex_k[k] == K_CBNZ));
            check({p, "ex_UBranch"},32'(o.ex_ubranch),32'(ex_k[k] == K_B));
            check({p, "ex_BrNZ"},   32'(o.ex_brnz),   32'(ex_k[k] == K_CBNZ));
            check({p, "ex_rd"},     32'(o.ex_rd),     32'(ex_r[k]));
            check({p, "mem_valid"}, 32'(o.mem_valid), 32'(mem_k[k] != 0));
            check({p, "mem_MemRead"},  32'(o.mem_memread),  32'(mem_k[k] == K_LDUR));
            check({p, "mem_MemWrite"}, 32'(o.mem_memwrite), 32'(mem_k[k] == K_STUR));
            check({p, "mem_rd"},    32'(o.mem_rd),    32'(mem_r[k]));
            check({p, "wb_valid"},  32'(o.wb_valid),  32'(wb_k[k] != 0));
            check({p, "wb_MemtoReg"}, 32'(o.wb_memtoreg), 32'(wb_k[k] == K_LDUR));
            check({p, "wb_RegWrite"}, 32'(o.wb_regwrite), 32'(wb_k[k] == K_LDUR || wb_k[k] == K_ADDI || wb_k[k] == K_R));
            check({p, "wb_rd"},     32'(o.wb_rd),     32'(wb_r[k]));
            check({p, "stall_cnt"}, 32'(o.stall_cnt), 32'(scnt[k]));
            check({p, "flush_cnt"}, 32'(o.flush_cnt), 32'(fcnt[k]));
        end
    endtask

    // One clock: drive ID inputs, check mid-cycle, advance model alongside the DUT edge.
    task automatic cycle(input logic [10:0] op, input logic v, input logic [4:0] rn,
                         input logic [4:0] rm, input logic [4:0] rt, input logic bt);
        in_op = op; in_v = v; in_rn = rn; in_rm = rm; in_rt = rt; in_bt = bt;
        @(negedge clk);
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Issue with IF/ID held while the model says the instruction is stalled (dut_a view).
    task automatic issue(input logic [10:0] op, input logic [4:0] rn, input logic [4:0] rm,
                         input logic [4:0] rt, input logic bt);
        bit again;
        for (int i = 0; i < 4; i++) begin
            in_op = op; in_v = 1'b1; in_rn = rn; in_rm = rm; in_rt = rt; in_bt = bt;
            again = exp_hz(0);
            cycle(op, 1'b1, rn, rm, rt, bt);
            if (!again) break;
        end
    endtask

    function automatic logic [4:0] rnd_reg();
        int r;
        r = int'($urandom_range(0, 4));
        if (r == 4) return 5'($urandom);
        return (r == 3) ? 5'd31 : 5'(r + 1);
    endfunction

    function automatic logic [10:0] rnd_op();
        case ($urandom_range(0, 11))
            0, 1: return 11'd1986;
            2:  return 11'd1984;
            3:  return {8'd180, 3'($urandom)};
            4:  return {8'd181, 3'($urandom)};
            5:  return {6'd5, 5'($urandom)};
            6:  return {10'd580, 1'($urandom)};
            7:  return {10'd836, 1'($urandom)};
            8:  return 11'd1112;
            9:  return 11'd1624;
            10: return ($urandom_range(0, 1) == 0) ? 11'd1104 : 11'd1360;
            default: return 11'($urandom);
        endcase
    endfunction

    initial begin
        model_reset();
        #1 rst = 1'b0;
        #2 check_all();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // Load-use: LDUR X1 then ADD X2,X1,X3 -> one stall, ADD reaches EX afterwards.
        issue(11'd1986, 5'd2, 5'd0, 5'd1, 1'b0);
        issue(11'd1112, 5'd1, 5'd3, 5'd2, 1'b0);
        check("plan.stall_cnt_1", 32'(obs_a.stall_cnt), 32'd1);
        check("plan.add_aluop",   32'(obs_a.ex_aluop),  32'd2);
        // X31 never hazards; STUR data register does.
        issue(11'd1986, 5'd2, 5'd0, 5'd31, 1'b0);
        issue(11'd1112, 5'd31, 5'd3, 5'd2, 1'b0);
        check("plan.xzr_no_stall", 32'(obs_a.stall_cnt), 32'd1);
        issue(11'd1986, 5'd2, 5'd0, 5'd1, 1'b0);
        issue(11'd1984, 5'd2, 5'd0, 5'd1, 1'b0);
        check("plan.stur_stall", 32'(obs_a.stall_cnt), 32'd2);
        // Hazard coinciding with a taken branch: flush wins.
        issue(11'd1986, 5'd2, 5'd0, 5'd1, 1'b0);
        issue(11'd1440, 5'd0, 5'd0, 5'd1, 1'b1);
        check("plan.flush_cnt",   32'(obs_a.flush_cnt), 32'd1);
        check("plan.flush_stall", 32'(obs_a.stall_cnt), 32'd2);
        check("plan.flush_exv",   32'(obs_a.ex_valid),  32'd0);
        // ADDI is legal only with the extended ISA.
        issue(11'd1160, 5'd4, 5'd0, 5'd5, 1'b0);
        check("plan.addi_alusrc", 32'(obs_a.ex_alusrc), 32'd1);
        check("plan.addi_aluop",  32'(obs_a.ex_aluop),  32'd2);
        check("plan.addi_ill_exv", 32'(obs_b.ex_valid), 32'd0);
        for (int i = 0; i < 3; i++) cycle(11'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        // Counter saturation on the narrow instance.
        for (int i = 0; i < 20; i++) begin
            issue(11'd1986, 5'd2, 5'd0, 5'd1, 1'b0);
            issue(11'd1112, 5'd1, 5'd3, 5'd2, 1'b0);
        end
        check("plan.sat_b", 32'(obs_b.stall_cnt), 32'd15);
        check("plan.cnt_a", 32'(obs_a.stall_cnt), 32'd22);

        // Asynchronous reset with every stage valid.
        issue(11'd1112, 5'd1, 5'd2, 5'd3, 1'b0);
        issue(11'd1986, 5'd4, 5'd0, 5'd5, 1'b0);
        issue(11'd1984, 5'd6, 5'd0, 5'd7, 1'b0);
        check("plan.pre_rst_wbv", 32'(obs_a.wb_valid), 32'd1);
        #2;
        in_op = '0; in_v = 1'b0; in_rn = '0; in_rm = '0; in_rt = '0; in_bt = 1'b0;
        rst = 1'b0;
        model_reset();
        #1 check_all();
        @(posedge clk); #1;
        rst = 1'b1;

        // Randomized stream.
        for (int i = 0; i < 800; i++)
            cycle(rnd_op(), 1'($urandom_range(0, 9) != 0), rnd_reg(), rnd_reg(), rnd_reg(),
                  1'($urandom_range(0, 7) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
